// File: rtl/xor_stream_decoder_32bit.sv
// XOR stream decoder: ciphertext ^ 32-bit Galois LFSR keystream, one word per cycle.
// Optional XOR_DEC_BYPASS_EN adds a bypass input that passes words through undecoded.
module xor_stream_decoder_32bit #(
  parameter logic [31:0] SEED = 32'hACE1_0001,
  parameter logic [31:0] TAPS = 32'h8020_0003
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        seed_load,
  input  logic [31:0] seed_in,
`ifdef XOR_DEC_BYPASS_EN
  input  logic        bypass,
`endif
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [15:0] word_count
);

  logic [31:0] ks;
  logic        accept;
  logic        pass;

  function automatic logic [31:0] step(input logic [31:0] k);
    return k[0] ? ((k >> 1) ^ TAPS) : (k >> 1);
  endfunction

`ifdef XOR_DEC_BYPASS_EN
  assign pass = bypass;
`else
  assign pass = 1'b0;
`endif

  assign in_ready = !seed_load && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Keystream and count; seed_load blocks accept, so the two branches never collide.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ks         <= SEED;
      word_count <= '0;
    end else if (seed_load) begin
      ks         <= (seed_in == '0) ? SEED : seed_in;
      word_count <= '0;
    end else if (accept) begin
      if (!pass) ks <= step(ks);
      word_count <= word_count + 16'd1;
    end
  end

  // Output register drains independently of seed loads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= pass ? in_data : (in_data ^ ks);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xor_stream_decoder_32bit.sv
// Self-checking bench for xor_stream_decoder_32bit: behavioural model plus directed literal checks.
module tb_xor_stream_decoder_32bit;
  localparam logic [31:0] SEED = 32'hACE1_0001;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        seed_load;
  logic [31:0] seed_in;
  logic        bypass;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] word_count;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  xor_stream_decoder_32bit #(.SEED(SEED), .TAPS(TAPS)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .seed_load  (seed_load),
    .seed_in    (seed_in),
`ifdef XOR_DEC_BYPASS_EN
    .bypass     (bypass),
`endif
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .word_count (word_count)
  );

  function automatic logic [31:0] lfsr_next(input logic [31:0] k);
    return k[0] ? ((k >> 1) ^ TAPS) : (k >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state as the specification describes it.
  logic [31:0] m_ks, m_od;
  logic [15:0] m_cnt;
  logic        m_ov;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ks = SEED; m_cnt = 0; m_ov = 0; m_od = 0;
    end else if (seed_load) begin
      m_ks  = (seed_in == 0) ? SEED : seed_in;
      m_cnt = 0;
      if (m_ov && out_ready) m_ov = 0;
    end else if (in_valid && (!m_ov || out_ready)) begin
      m_od  = bypass ? in_data : (in_data ^ m_ks);
      m_ov  = 1;
      m_ks  = bypass ? m_ks : lfsr_next(m_ks);
      m_cnt = m_cnt + 1;
    end else if (out_ready) begin
      m_ov = 0;
    end
  end

  always @(negedge clk) begin
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    if (m_ov) chk("out_data", out_data, m_od);
    chk("word_count", {16'd0, word_count}, {16'd0, m_cnt});
    chk("in_ready", {31'd0, in_ready}, {31'd0, !seed_load && (!m_ov || out_ready)});
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  logic [31:0] held;

  initial begin
    reset_n = 0; seed_load = 0; seed_in = 0; bypass = 0;
    in_valid = 0; in_data = 0; out_ready = 1;
    repeat (2) cyc();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_word_count", {16'd0, word_count}, 32'd0);
    reset_n = 1;
    #1 chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // First two words pin the keystream start and one LFSR step.
    in_valid = 1; in_data = 0;
    cyc();
    chk("first_word", out_data, 32'hACE1_0001);
    chk("first_count", {16'd0, word_count}, 32'd1);
    in_data = 32'hD650_8003;
    cyc();
    chk("second_word", out_data, 32'h0000_0000);
    in_valid = 0;
    cyc();

    // Stall with out_ready low for 5 cycles.
    out_ready = 0; in_valid = 1; in_data = 32'h1111_2222;
    cyc();
    held = out_data;
    in_data = 32'h3333_4444;
    repeat (5) begin
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      cyc();
      chk("stall_out_data", out_data, held);
    end
    out_ready = 1;
    cyc();
    in_valid = 0;
    cyc();

    // Zero seed load with a competing word.
    seed_load = 1; seed_in = 0; in_valid = 1; in_data = 0;
    #1 chk("seed_in_ready", {31'd0, in_ready}, 32'd0);
    cyc();
    seed_load = 0;
    chk("seed_count", {16'd0, word_count}, 32'd0);
    cyc();
    chk("seed_word", out_data, 32'hACE1_0001);
    chk("seed_word_count", {16'd0, word_count}, 32'd1);

    // 65537 words wrap the counter to 1.
    seed_load = 1; seed_in = 32'h0BAD_F00D;
    cyc();
    seed_load = 0;
    repeat (65537) begin
      in_data = $urandom;
      cyc();
    end
    chk("wrap_count", {16'd0, word_count}, 32'd1);

    // Reset mid-stream discards pending output.
    out_ready = 0;
    cyc();
    reset_n = 0;
    #1 chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_count", {16'd0, word_count}, 32'd0);
    in_valid = 0; out_ready = 1;
    cyc();
    reset_n = 1;
    cyc();
`ifdef XOR_DEC_BYPASS_EN
    bypass = 1; in_valid = 1; in_data = 32'h1234_5678;
    cyc();
    chk("bypass_word", out_data, 32'h1234_5678);
    bypass = 0;
`endif
    in_valid = 1; in_data = 0;
    cyc();
    chk("post_reset_word", out_data, 32'hACE1_0001);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      seed_load = $urandom_range(0, 31) == 0;
      seed_in   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      in_data   = $urandom;
`ifdef XOR_DEC_BYPASS_EN
      bypass    = $urandom_range(0, 7) == 0;
`endif
      cyc();
    end
    in_valid = 0; seed_load = 0; out_ready = 1; bypass = 0;
    repeat (2) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
